sd_request_arbiter: RTL and testbench



---
 rtl/sd_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/sd_request_arbiter.sv | 106 ++++++++++
 tb/tb_sd_request_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and state encoding for the SD request arbiter
package sd_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W = 26;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, XFER, RELEASE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] j;
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr) + i) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/sd_request_arbiter.sv
// sd_request_arbiter: round-robin sharing of one SD sector engine among NUM_REQ clients (optional watchdog: SD_ARB_TIMEOUT_EN)
module sd_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SECTOR_BYTES = sd_pkg::SECTOR_BYTES
`ifdef SD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_op,
  input  logic [sd_pkg::ADDR_W*NUM_REQ-1:0]   req_sector,
  input  logic [8*NUM_REQ-1:0]                req_wdata,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  byte_stb,
  output logic [$clog2(SECTOR_BYTES)-1:0]     byte_index,
  output logic [7:0]                          rdata,
  output logic [NUM_REQ-1:0]                  done,
  output logic [NUM_REQ-1:0]                  err,
  output logic                                sd_op_code,
  output logic                                sd_execute,
  output logic [sd_pkg::ADDR_W-1:0]           sd_sector_address,
  output logic [7:0]                          sd_outgoing_byte,
  input  logic [7:0]                          sd_incoming_byte,
  input  logic                                sd_finished_byte,
  input  logic                                sd_finished_sector,
  input  logic                                sd_busy
);
  import sd_pkg::*;
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(SECTOR_BYTES);
  state_t state, state_n;
  logic [PW-1:0] ptr, win, pick;
  logic [NUM_REQ-1:0] pick_oh;
  logic any;
  logic [BW:0] cnt;
  logic prev_byte, prev_sector, byte_edge, sector_edge, take, timeout;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (.req(req), .ptr(ptr), .gnt(pick_oh), .idx(pick), .any(any));
  assign byte_edge = sd_finished_byte & ~prev_byte;
  assign sector_edge = sd_finished_sector & ~prev_sector;
  assign take = state == XFER && byte_edge && cnt < (BW+1)'(SECTOR_BYTES);
  assign sd_outgoing_byte = |gnt ? req_wdata[8*win +: 8] : 8'hFF;
`ifdef SD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign timeout = (state == LAUNCH || state == XFER) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    tcnt <= (rst || state_n != state || byte_edge) ? '0 : tcnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any ? GRANT : IDLE;
      GRANT:   state_n = LAUNCH;
      LAUNCH:  state_n = timeout ? IDLE : sd_busy ? LAUNCH : XFER;
      XFER:    state_n = timeout ? IDLE : sector_edge ? RELEASE : XFER;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      win <= '0;
      gnt <= '0;
      byte_stb <= '0;
      done <= '0;
      err <= '0;
      sd_execute <= 1'b0;
      sd_op_code <= 1'b0;
      sd_sector_address <= '0;
      byte_index <= '0;
      rdata <= '0;
      cnt <= '0;
      prev_byte <= 1'b0;
      prev_sector <= 1'b0;
    end else begin
      prev_byte <= sd_finished_byte;
      prev_sector <= sd_finished_sector;
      byte_stb <= take ? gnt : '0;
      done <= state == RELEASE ? gnt : '0;
      err <= timeout ? gnt : '0;
      sd_execute <= state == LAUNCH && !sd_busy && !timeout;
      if (state == IDLE && any) begin
        win <= pick;
        gnt <= pick_oh;
        sd_op_code <= req_op[pick];
        sd_sector_address <= req_sector[ADDR_W*pick +: ADDR_W];
        cnt <= '0;
      end
      if (take) begin
        byte_index <= cnt[BW-1:0];
        rdata <= sd_op_code == OP_READ ? sd_incoming_byte : rdata;
        cnt <= cnt + 1'b1;
      end
      if (state == RELEASE || timeout) begin
        gnt <= '0;
        ptr <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sd_request_arbiter.sv
// tb_sd_request_arbiter: scoreboard bench for sd_request_arbiter against a round-robin reference model
module tb_sd_request_arbiter;
  localparam int N = 4;
  typedef struct { int c; logic op; logic [25:0] sec; } txn_t;
  typedef struct { int idx; logic [7:0] d; bit chk; } byte_t;
  typedef struct { int c; bit after_stb; } done_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, req_op = '0;
  logic [26*N-1:0] req_sector = '0;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0] gnt, byte_stb, done, err;
  logic [8:0] byte_index;
  logic [7:0] rdata, sd_outgoing_byte;
  logic [7:0] sd_incoming_byte = '0;
  logic sd_op_code, sd_execute;
  logic sd_finished_byte = 0, sd_finished_sector = 0, sd_busy = 0;
  logic [25:0] sd_sector_address;
  int checks = 0, errors = 0, n_exec = 0, n_err = 0, ptr_m = 0;
  int nxt [N];
  txn_t q_gnt[$], q_exec[$], tg, te;
  byte_t q_byte[$], tb;
  done_t q_done[$], td;
  int q_err[$], terr;
  logic [N-1:0] gnt_d = '0, stb_d = '0;

  sd_request_arbiter #(
    .NUM_REQ(N)
`ifdef SD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_sector(req_sector),
    .req_wdata(req_wdata), .gnt(gnt), .byte_stb(byte_stb), .byte_index(byte_index),
    .rdata(rdata), .done(done), .err(err), .sd_op_code(sd_op_code),
    .sd_execute(sd_execute), .sd_sector_address(sd_sector_address),
    .sd_outgoing_byte(sd_outgoing_byte), .sd_incoming_byte(sd_incoming_byte),
    .sd_finished_byte(sd_finished_byte), .sd_finished_sector(sd_finished_sector),
    .sd_busy(sd_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int c, input int k);
    return 8'(k) ^ 8'h5A ^ 8'((3 - c) << 4);
  endfunction

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!gnt[i]) nxt[i] = 0;
      else if (byte_stb[i]) nxt[i] = int'(byte_index) + 1;
      req_wdata[8*i +: 8] = pat(i, nxt[i]);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 0 && gnt_d == 0) begin
        if (q_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
        else begin
          tg = q_gnt.pop_front();
          check("gnt", 32'(gnt), 32'(1) << tg.c);
        end
      end
      if (sd_execute) begin
        n_exec++;
        if (q_exec.size() == 0) check("exec_unexpected", 32'(sd_execute), 0);
        else begin
          te = q_exec.pop_front();
          check("exec_client", 32'(gnt), 32'(1) << te.c);
          check("exec_sector", 32'(sd_sector_address), 32'(te.sec));
          check("exec_op", 32'(sd_op_code), 32'(te.op));
          check("exec_busy", 32'(sd_busy), 0);
        end
      end
      if (byte_stb != 0) begin
        if (q_byte.size() == 0) check("stb_unexpected", 32'(byte_stb), 0);
        else begin
          tb = q_byte.pop_front();
          check("stb_client", 32'(byte_stb), 32'(gnt));
          check("byte_index", 32'(byte_index), 32'(tb.idx));
          if (tb.chk) check("rdata", 32'(rdata), 32'(tb.d));
        end
      end
      if (done != 0) begin
        if (q_done.size() == 0) check("done_unexpected", 32'(done), 0);
        else begin
          td = q_done.pop_front();
          check("done", 32'(done), 32'(1) << td.c);
          check("done_after_stb", 32'(|stb_d), 32'(td.after_stb));
          check("done_gnt_drop", 32'(gnt), 0);
          check("idle_wdata", 32'(sd_outgoing_byte), 32'hFF);
        end
      end
      if (err != 0) begin
        n_err++;
        if (q_err.size() == 0) check("err_unexpected", 32'(err), 0);
        else begin
          terr = q_err.pop_front();
          check("err", 32'(err), 32'(1) << terr);
          check("err_gnt_drop", 32'(gnt), 0);
        end
      end
    end
    gnt_d = rst ? '0 : gnt;
    stb_d = rst ? '0 : byte_stb;
  end

  // cut: 0 normal, >0 reset after that many bytes, <0 stall until watchdog
  task automatic txn(input int nbytes, input logic [N-1:0] nreq, input bit simul, input int cut, input int busy);
    int w, e0, e1;
    txn_t t;
    byte_t b;
    done_t d;
    w = pick(req);
    check("model_has_winner", 32'(w >= 0), 1);
    if (w < 0) return;
    t.c = w;
    t.op = req_op[w];
    t.sec = req_sector[26*w +: 26];
    e0 = n_exec;
    q_gnt.push_back(t);
    q_exec.push_back(t);
    if (busy > 0) begin
      sd_busy = 1;
      for (int i = 0; i < 20 && gnt == 0; i++) @(posedge clk);
      check("busy_gnt", 32'(|gnt), 1);
      repeat (busy) @(posedge clk);
      #1 sd_busy = 0;
      check("exec_during_busy", 32'(n_exec - e0), 0);
      @(negedge clk);
      check("exec_held", 32'(sd_execute), 0);
      @(negedge clk);
      check("exec_first_free", 32'(sd_execute), 1);
    end
    for (int i = 0; i < 200 && n_exec == e0; i++) @(posedge clk);
    check("exec_seen", 32'(n_exec - e0), 1);
    #1;
    req = nreq;
    req_op = N'($urandom);
    for (int i = 0; i < N; i++) req_sector[26*i +: 26] = 26'($urandom);
    for (int k = 0; k < (cut > 0 ? cut : nbytes); k++) begin
      repeat (3) @(posedge clk);
      #1;
      sd_incoming_byte = 8'($urandom);
      if (k < 512) begin
        b.idx = k;
        b.d = sd_incoming_byte;
        b.chk = !t.op;
        q_byte.push_back(b);
        if (t.op) check("wdata", 32'(sd_outgoing_byte), 32'(pat(w, k)));
      end
      if (simul && cut == 0 && k == nbytes - 1) begin
        d.c = w;
        d.after_stb = 1;
        q_done.push_back(d);
        sd_finished_sector = 1;
      end
      sd_finished_byte = 1;
      @(posedge clk);
      #1 sd_finished_byte = 0;
      sd_finished_sector = 0;
    end
    if (cut > 0) begin
      @(posedge clk);
      #1 rst = 1;
      req = '0;
      @(posedge clk);
      #1 rst = 0;
      ptr_m = 0;
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_done", 32'(done), 0);
      repeat (10) @(posedge clk);
      #1;
      return;
    end
    if (cut < 0) begin
      q_err.push_back(w);
      e1 = n_err;
      for (int i = 0; i < 300 && n_err == e1; i++) @(posedge clk);
      check("err_seen", 32'(n_err - e1), 1);
      ptr_m = (w + 1) % N;
      return;
    end
    if (!simul) begin
      repeat (2) @(posedge clk);
      #1;
      d.c = w;
      d.after_stb = 0;
      q_done.push_back(d);
      sd_finished_sector = 1;
      @(posedge clk);
      #1 sd_finished_sector = 0;
    end
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt), 0);
    check("rst_stb0", 32'(byte_stb), 0);
    check("rst_done0", 32'(done), 0);
    check("rst_err0", 32'(err), 0);
    check("rst_exec0", 32'(sd_execute), 0);
    check("rst_op0", 32'(sd_op_code), 0);
    check("rst_sector0", 32'(sd_sector_address), 0);
    check("rst_index0", 32'(byte_index), 0);
    check("rst_rdata0", 32'(rdata), 0);
    check("rst_wdata_ff", 32'(sd_outgoing_byte), 32'hFF);
    rst = 0;
    req = 4'b0100;
    req_op[2] = 1'b0;
    req_sector[52 +: 26] = 26'h000123;
    txn(512, 4'b0000, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 req = 4'b0100;
    txn(512, 4'b0000, 0, 200, 0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) txn($urandom_range(4, 24), i < 4 ? 4'b1111 : 4'b0000, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 req = 4'b1000;
    req_op[3] = 1'b1;
    txn(512, 4'b0000, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 req = 4'b0010;
    txn(16, 4'b0000, 0, 0, 50);
    repeat (6) @(posedge clk);
    #1 req = 4'b0001;
    txn(512, 4'b0000, 1, 0, 0);
    repeat (6) @(posedge clk);
    #1 req = 4'($urandom_range(1, 15));
    for (int i = 0; i < 12; i++)
      txn($urandom_range(1, 40), i < 11 ? 4'($urandom_range(1, 15)) : 4'b0000, 1'($urandom), 0, 0);
    repeat (6) @(posedge clk);
    #1 req = 4'b0100;
    txn(514, 4'b0000, 0, 0, 0);
`ifdef SD_ARB_TIMEOUT_EN
    repeat (6) @(posedge clk);
    #1 req = 4'b0011;
    txn(10, 4'b0011, 0, -1, 0);
    txn(8, 4'b0000, 0, 0, 0);
`endif
    repeat (20) @(posedge clk);
    #1;
    check("queues_drained", 32'(q_gnt.size() + q_exec.size() + q_byte.size() + q_done.size() + q_err.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
